// File: rtl/team_06_i2s_tx_if.sv
// team_06_i2s_tx_if: valid/ready sample handshake between the sample source and the I2S transmitter.
interface team_06_i2s_tx_if;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/team_06_i2s_tx.sv
// team_06_i2s_tx: 8-bit I2S transmitter with a one-sample holding register, MSB first, left slot ws=0.
// Define TEAM_06_I2S_TX_REPEAT_EN to resend the last loaded sample on underrun instead of 8'h00.
module team_06_i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    team_06_i2s_tx_if.slave sif,
    output logic            i2s_bclk,
    output logic            i2s_ws,
    output logic            i2s_sd,
    output logic            underrun,
    output logic            busy
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    hold;
    logic [7:0]    shift;
    logic [7:0]    word;
    logic          hold_full;
    logic          accept;
    logic          tick;
    logic          fall;
    assign sif.sample_ready = !hold_full;
    assign busy = state != IDLE;
    assign accept = sif.sample_valid && !hold_full;
    assign tick = div_cnt == DW'(CLK_DIV - 1);
    assign fall = tick && i2s_bclk;
`ifdef TEAM_06_I2S_TX_REPEAT_EN
    // hold is only overwritten once emptied, so it always holds the last loaded sample (0 after reset)
    assign word = hold;
`else
    assign word = hold_full ? hold : 8'h00;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            hold      <= '0;
            shift     <= '0;
            hold_full <= 1'b0;
            i2s_bclk  <= 1'b0;
            i2s_ws    <= 1'b0;
            i2s_sd    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept) begin
                hold      <= sif.sample_in;
                hold_full <= 1'b1;
            end
            if (state == IDLE) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                if (enable && hold_full) state <= RUN;
            end else begin
                if (state == RUN && !enable) state <= DRAIN;
                if (state == DRAIN && enable) state <= RUN;
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) i2s_bclk <= !i2s_bclk;
                if (fall) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) i2s_ws <= !i2s_ws;
                    if (bit_cnt != 3'd0) begin
                        i2s_sd <= shift[7];
                        shift  <= {shift[6:0], 1'b0};
                    end else if (state == DRAIN && !i2s_ws) begin
                        // right-slot LSB has had its full bit period; stop before the next left slot
                        state   <= IDLE;
                        bit_cnt <= 3'd0;
                        i2s_sd  <= 1'b0;
                    end else begin
                        i2s_sd    <= word[7];
                        shift     <= {word[6:0], 1'b0};
                        hold_full <= accept;
                        underrun  <= !hold_full;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_team_06_i2s_tx.sv
// tb_team_06_i2s_tx: directed checks of framing, start latency, underrun, backpressure, drain and reset.
module tb_team_06_i2s_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic i2s_bclk, i2s_ws, i2s_sd, underrun, busy;
    int passed = 0;
    int total = 0;
    int ur_cnt = 0;
    int cyc = 0;
    int ur0, a1, a2, a3, a4;
    logic [15:0] d, w;
    logic drop;
`ifdef TEAM_06_I2S_TX_REPEAT_EN
    localparam logic [7:0] UR_BYTE = 8'hA5;
`else
    localparam logic [7:0] UR_BYTE = 8'h00;
`endif

    team_06_i2s_tx_if sif();

    team_06_i2s_tx #(.CLK_DIV(2)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .sif(sif),
        .i2s_bclk(i2s_bclk),
        .i2s_ws(i2s_ws),
        .i2s_sd(i2s_sd),
        .underrun(underrun),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (underrun) ur_cnt <= ur_cnt + 1;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // receiver model: samples sd and ws on each bclk rise, MSB first
    task automatic collect(input int n, output logic [15:0] dd, output logic [15:0] ww, output logic dr);
        logic prev;
        int budget;
        prev = i2s_bclk;
        budget = n * 8 + 16;
        dd = '0;
        ww = '0;
        dr = 1'b0;
        for (int i = 0; i < n; ) begin
            step();
            if (!busy) dr = 1'b1;
            if (i2s_bclk && !prev) begin
                dd = {dd[14:0], i2s_sd};
                ww = {ww[14:0], i2s_ws};
                i++;
            end
            prev = i2s_bclk;
            budget--;
            if (budget == 0) begin
                total++;
                $error("FAIL collect: got %0d of %0d bclk rises", i, n);
                break;
            end
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!sif.sample_ready && k < 200) begin
            step();
            k++;
        end
        if (!sif.sample_ready) begin
            total++;
            $error("FAIL %s: sample_ready still 0 after %0d cycles", tag, k);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 400) begin
            step();
            k++;
        end
        if (busy) begin
            total++;
            $error("FAIL %s: busy still 1 after %0d cycles", tag, k);
        end
    endtask

    initial begin
        sif.sample_in = 8'h00;
        sif.sample_valid = 1'b0;
        step(2);
        check("reset_outputs", {i2s_bclk, i2s_ws, i2s_sd, underrun, busy, sif.sample_ready}, 6'b000001);
        rst = 1'b0;
        step();
        // stereo frame 0xA5 / 0x3C
        enable = 1'b1;
        sif.sample_in = 8'hA5;
        sif.sample_valid = 1'b1;
        step();
        check("a5_accepted_ready", sif.sample_ready, 1'b0);
        check("idle_at_accept", busy, 1'b0);
        sif.sample_in = 8'h3C;
        step();
        check("run_entry", {busy, i2s_bclk}, 2'b10);
        step(3);
        check("before_first_fall", {i2s_bclk, i2s_sd}, 2'b10);
        step();
        check("first_msb_5_edges", {i2s_bclk, i2s_ws, i2s_sd}, 3'b001);
        check("ready_after_load", sif.sample_ready, 1'b1);
        step();
        check("3c_accepted", sif.sample_ready, 1'b0);
        sif.sample_valid = 1'b0;
        collect(16, d, w, drop);
        check("stereo_data", d, 16'hA53C);
        check("stereo_ws", w, 16'h01FE);
        check("stereo_busy", drop, 1'b0);
        check("stereo_no_underrun", ur_cnt, 0);
        enable = 1'b0;
        wait_idle("stereo_drain");
        check("stereo_idle_outs", {i2s_bclk, i2s_ws, i2s_sd, sif.sample_ready}, 4'b0001);
        check("stereo_drain_no_underrun", ur_cnt, 0);
        // underrun on right slot
        ur0 = ur_cnt;
        enable = 1'b1;
        sif.sample_in = 8'hA5;
        sif.sample_valid = 1'b1;
        step();
        sif.sample_valid = 1'b0;
        step(5);
        collect(16, d, w, drop);
        check("underrun_data", d, {8'hA5, UR_BYTE});
        check("underrun_ws", w, 16'h01FE);
        check("underrun_one_pulse", ur_cnt - ur0, 1);
        enable = 1'b0;
        wait_idle("underrun_drain");
        check("underrun_idle_outs", {i2s_bclk, i2s_ws, i2s_sd, busy}, 4'b0000);
        check("underrun_total", ur_cnt - ur0, 1);
        // backpressure with 0x11, 0x22, 0x33, 0x44, then enable drop mid left slot
        ur0 = ur_cnt;
        enable = 1'b1;
        sif.sample_in = 8'h11;
        sif.sample_valid = 1'b1;
        step();
        a1 = cyc;
        sif.sample_in = 8'h22;
        check("bp_ready_low", sif.sample_ready, 1'b0);
        wait_ready("bp_22");
        step();
        a2 = cyc;
        sif.sample_in = 8'h33;
        check("bp_22_timing", a2 - a1, 6);
        check("bp_ready_low_22", sif.sample_ready, 1'b0);
        wait_ready("bp_33");
        step();
        a3 = cyc;
        sif.sample_in = 8'h44;
        check("bp_33_timing", a3 - a2, 32);
        wait_ready("bp_44");
        step();
        a4 = cyc;
        sif.sample_valid = 1'b0;
        check("bp_44_timing", a4 - a3, 32);
        step(8);
        enable = 1'b0;
        wait_ready("drop_55");
        sif.sample_in = 8'h55;
        sif.sample_valid = 1'b1;
        step();
        sif.sample_valid = 1'b0;
        wait_idle("drop_drain");
        check("drop_idle_cycle", cyc - a4, 63);
        check("drop_idle_outs", {i2s_bclk, i2s_ws, i2s_sd, busy}, 4'b0000);
        check("drop_sample_kept", sif.sample_ready, 1'b0);
        check("bp_no_underrun", ur_cnt - ur0, 0);
        // re-enable during drain: 0x55 left, 0x66 right, then 0x77 left without idling
        enable = 1'b1;
        step();
        wait_ready("re_66");
        sif.sample_in = 8'h66;
        sif.sample_valid = 1'b1;
        step();
        sif.sample_valid = 1'b0;
        step(8);
        enable = 1'b0;
        wait_ready("re_77");
        sif.sample_in = 8'h77;
        sif.sample_valid = 1'b1;
        step();
        sif.sample_valid = 1'b0;
        enable = 1'b1;
        collect(16, d, w, drop);
        check("reenable_data", d, 16'h6677);
        check("reenable_ws", w, 16'hFE01);
        check("reenable_busy_held", drop, 1'b0);
        check("reenable_no_underrun", ur_cnt - ur0, 0);
        // asynchronous reset mid-slot with a sample buffered
        sif.sample_in = 8'h88;
        sif.sample_valid = 1'b1;
        step();
        sif.sample_valid = 1'b0;
        check("pre_reset_state", {i2s_bclk, i2s_ws, i2s_sd, busy, sif.sample_ready}, 5'b11110);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_outs", {i2s_bclk, i2s_ws, i2s_sd, underrun, busy, sif.sample_ready}, 6'b000001);
        step(2);
        rst = 1'b0;
        step(2);
        check("post_reset_idle", {busy, sif.sample_ready, i2s_bclk}, 3'b010);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
